// File: rtl/instr_encoder_if.sv
// Field-set input and instruction-memory write bus for instr_encoder.
// The master side presents field sets and accepts writes; the slave side is the encoder.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [ADDR_W-1:0] in_target;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
        output imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
        input  imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded R/lw/sw/beq field sets into MIPS words and writes them to
// instruction memory at consecutive word addresses through a one-entry output register.
module instr_encoder #(
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       DEPTH_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W-2:0] count,
    output logic              full,
    output logic              err
);
    typedef enum logic [1:0] {
        K_R   = 2'b00,
        K_LW  = 2'b01,
        K_SW  = 2'b10,
        K_BEQ = 2'b11
    } kind_e;

    localparam int unsigned       XW       = (ADDR_W + 2 > 18) ? ADDR_W + 2 : 18;
    localparam logic [ADDR_W-2:0] LP_DEPTH = (ADDR_W-1)'(DEPTH_WORDS);

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W-2:0] r_count;
    logic              r_full;
    logic              r_err;

    logic              w_in_ready;
    logic              w_fire;
    logic [XW-1:0]     w_pc_x;
    logic [XW-1:0]     w_diff;
    logic signed [XW-1:0] w_off;
    logic              w_off_ovf;
    logic              w_reject;
    logic [31:0]       w_word;
    logic [ADDR_W-2:0] w_count_nxt;

    assign w_in_ready = ~reset & ~r_full & ~start & (~r_we | bus.imem_ready);
    assign w_fire     = bus.in_valid & w_in_ready;

    // Offset math is done wide enough that no intermediate can wrap; the
    // 16-bit field is legal only when the bits above 15 are pure sign extension.
    assign w_pc_x    = XW'(BASE_ADDR) + XW'({r_count, 2'b00});
    assign w_diff    = XW'(bus.in_target) - (w_pc_x + XW'(4));
    assign w_off     = $signed(w_diff) >>> 2;
    assign w_off_ovf = ~((&w_off[XW-1:15]) | ~(|w_off[XW-1:15]));

    always_comb begin
        w_word   = '0;
        w_reject = 1'b0;
        unique case (kind_e'(bus.in_kind))
            K_R:   w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, bus.in_funct};
            K_LW:  w_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            K_SW:  w_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            K_BEQ: begin
                w_word   = {6'b000100, bus.in_rs, bus.in_rt, w_off[15:0]};
                w_reject = (|bus.in_target[1:0]) | w_off_ovf;
            end
        endcase
    end

    assign w_count_nxt = r_count + (ADDR_W-1)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_wdata <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else if (start) begin
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (r_we && bus.imem_ready) begin
                r_we <= 1'b0;
            end
            if (w_fire) begin
                if (w_reject) begin
                    r_err <= 1'b1;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= w_pc_x[ADDR_W-1:0];
                    r_wdata <= w_word;
                    r_count <= w_count_nxt;
                    r_full  <= (w_count_nxt == LP_DEPTH);
                end
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign count          = r_count;
    assign full           = r_full;
    assign err            = r_err;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, beq offsets/rejects, stalls,
// full/start behaviour on a 4-word instance, and asynchronous reset mid-write.
module tb_instr_encoder;
    logic       clk;
    logic       reset;
    logic       start;
    logic       start4;
    logic [6:0] count;
    logic [6:0] count4;
    logic       full, full4;
    logic       err, err4;

    int checks = 0;
    int errors = 0;

    instr_encoder_if #(.ADDR_W(8)) bus  ();
    instr_encoder_if #(.ADDR_W(8)) bus4 ();

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'h00), .DEPTH_WORDS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus.slave),
        .count (count),
        .full  (full),
        .err   (err)
    );

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'h00), .DEPTH_WORDS(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start4),
        .bus   (bus4.slave),
        .count (count4),
        .full  (full4),
        .err   (err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                         input logic [7:0] target);
        bus.in_valid  = 1'b1;
        bus.in_kind   = kind;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_funct  = funct;
        bus.in_imm    = imm;
        bus.in_target = target;
    endtask

    task automatic drive4(input logic [4:0] i);
        bus4.in_valid  = 1'b1;
        bus4.in_kind   = 2'b01;
        bus4.in_rs     = i;
        bus4.in_rt     = i;
        bus4.in_rd     = '0;
        bus4.in_funct  = '0;
        bus4.in_imm    = {11'd0, i};
        bus4.in_target = '0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        bus.in_valid    = 1'b0;
        bus.imem_ready  = 1'b0;
        bus4.in_valid   = 1'b0;
        bus4.in_kind    = '0;
        bus4.in_rs      = '0;
        bus4.in_rt      = '0;
        bus4.in_rd      = '0;
        bus4.in_funct   = '0;
        bus4.in_imm     = '0;
        bus4.in_target  = '0;
        bus4.imem_ready = 1'b1;

        // Reset values
        tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_we", bus.imem_we, 0);
        chk("rst_addr", bus.imem_addr, 8'h00);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;

        // T1: lw
        bus.imem_ready = 1'b1;
        drive(2'b01, 16, 8, 0, 0, 16'd4, 0);
        #1 chk("t1_in_ready", bus.in_ready, 1);
        tick();
        chk("t1_we", bus.imem_we, 1);
        chk("t1_addr", bus.imem_addr, 8'h00);
        chk("t1_wdata", bus.imem_wdata, 32'h8E080004);
        chk("t1_count", count, 1);

        // T2: R then sw, back-to-back
        drive(2'b00, 8, 9, 10, 6'h20, 0, 0);
        tick();
        chk("t2r_we", bus.imem_we, 1);
        chk("t2r_addr", bus.imem_addr, 8'h04);
        chk("t2r_wdata", bus.imem_wdata, 32'h01095020);
        drive(2'b10, 16, 10, 0, 0, 16'd8, 0);
        tick();
        chk("t2s_addr", bus.imem_addr, 8'h08);
        chk("t2s_wdata", bus.imem_wdata, 32'hAE0A0008);
        chk("t2s_count", count, 3);

        // T3: beq backward, then misaligned target
        drive(2'b11, 8, 9, 0, 0, 0, 8'h00);
        tick();
        chk("t3_addr", bus.imem_addr, 8'h0C);
        chk("t3_wdata", bus.imem_wdata, 32'h1109FFFC);
        chk("t3_count", count, 4);
        drive(2'b11, 8, 9, 0, 0, 0, 8'h02);
        #1 chk("t3rej_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("t3rej_we", bus.imem_we, 0);
        chk("t3rej_err", err, 1);
        chk("t3rej_count", count, 4);

        // T4: write held while imem_ready is low
        bus.imem_ready = 1'b0;
        drive(2'b01, 1, 2, 0, 0, 16'h0010, 0);
        tick();
        chk("t4_addr", bus.imem_addr, 8'h10);
        chk("t4_wdata", bus.imem_wdata, 32'h8C220010);
        chk("t4_count", count, 5);
        drive(2'b00, 3, 4, 5, 6'h22, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_stall_in_ready", bus.in_ready, 0);
            chk("t4_stall_we", bus.imem_we, 1);
            chk("t4_stall_addr", bus.imem_addr, 8'h10);
            chk("t4_stall_wdata", bus.imem_wdata, 32'h8C220010);
            chk("t4_stall_count", count, 5);
        end
        bus.imem_ready = 1'b1;
        #1 chk("t4_release_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("t4_next_addr", bus.imem_addr, 8'h14);
        chk("t4_next_wdata", bus.imem_wdata, 32'h00642822);
        chk("t4_next_count", count, 6);
        tick();
        chk("t4_idle_we", bus.imem_we, 0);
        chk("t4_idle_count", count, 6);

        // start drops a pending write and refuses a simultaneous field set
        bus.imem_ready = 1'b0;
        drive(2'b10, 0, 1, 0, 0, 16'hFFFC, 0);
        tick();
        chk("st_pend_we", bus.imem_we, 1);
        chk("st_pend_addr", bus.imem_addr, 8'h18);
        drive(2'b01, 2, 3, 0, 0, 16'h0001, 0);
        start = 1'b1;
        #1 chk("st_in_ready", bus.in_ready, 0);
        tick();
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk("st_we", bus.imem_we, 0);
        chk("st_addr", bus.imem_addr, 8'h00);
        chk("st_count", count, 0);
        chk("st_err", err, 0);
        chk("st_full", full, 0);

        // beq forward: pc=0x04 after one word, target 0x20 -> off 6
        bus.imem_ready = 1'b1;
        drive(2'b01, 16, 8, 0, 0, 16'd4, 0);
        tick();
        drive(2'b11, 0, 0, 0, 0, 0, 8'h20);
        tick();
        bus.in_valid = 1'b0;
        chk("fwd_addr", bus.imem_addr, 8'h04);
        chk("fwd_wdata", bus.imem_wdata, 32'h10000006);
        chk("fwd_err", err, 0);
        tick();

        // T6: reset while a write is stalled
        bus.imem_ready = 1'b0;
        drive(2'b01, 16, 8, 0, 0, 16'd4, 0);
        tick();
        bus.in_valid = 1'b0;
        chk("t6_pend_we", bus.imem_we, 1);
        chk("t6_pend_addr", bus.imem_addr, 8'h08);
        #2 reset = 1'b1;
        #1;
        chk("t6_we", bus.imem_we, 0);
        chk("t6_addr", bus.imem_addr, 8'h00);
        chk("t6_wdata", bus.imem_wdata, 0);
        chk("t6_count", count, 0);
        chk("t6_err", err, 0);
        chk("t6_in_ready", bus.in_ready, 0);
        tick();
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        drive(2'b10, 16, 10, 0, 0, 16'd8, 0);
        tick();
        bus.in_valid = 1'b0;
        chk("t6_after_addr", bus.imem_addr, 8'h00);
        chk("t6_after_wdata", bus.imem_wdata, 32'hAE0A0008);
        chk("t6_after_count", count, 1);

        // T5: 4-word instance fills, stalls, restarts
        for (int i = 0; i < 4; i++) begin
            drive4(5'(i));
            #1 chk("t5_in_ready", bus4.in_ready, 1);
            tick();
            chk("t5_addr", bus4.imem_addr, 32'(4 * i));
            chk("t5_wdata", bus4.imem_wdata, {6'b100011, 5'(i), 5'(i), 16'(i)});
            chk("t5_count", count4, 32'(i + 1));
        end
        chk("t5_full", full4, 1);
        drive4(5'd4);
        #1 chk("t5_full_in_ready", bus4.in_ready, 0);
        tick();
        chk("t5_last_done_we", bus4.imem_we, 0);
        drive4(5'd5);
        tick();
        chk("t5_stall_in_ready", bus4.in_ready, 0);
        chk("t5_stall_count", count4, 4);
        chk("t5_stall_full", full4, 1);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("t5_start_count", count4, 0);
        chk("t5_start_full", full4, 0);
        #1 chk("t5_restart_in_ready", bus4.in_ready, 1);
        tick();
        bus4.in_valid = 1'b0;
        chk("t5_restart_addr", bus4.imem_addr, 8'h00);
        chk("t5_restart_wdata", bus4.imem_wdata, 32'h8CA50005);
        chk("t5_restart_count", count4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
